uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Byte-stream framer between the UART receive path (`uart_wrapper` RX side) and `control`.
- Pops raw bytes with the req/ready handshake and hunts for framed packets: SYNC, LEN, payload, CHK.
- Buffers the payload internally. Releases it to `control` on a valid/ready stream only after the check byte matches; bad or stalled frames are dropped.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 64, maximum payload bytes (1..255); also the depth of the buffer.
- TIMEOUT_CYCLES, 50000, maximum idle i_clk cycles between consecutive bytes inside a frame.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_data  in  8  head byte from UART RX FIFO
- i_rx_ready  in  1  UART RX FIFO holds a byte
- o_req  out  1  pop strobe to UART RX FIFO
- o_data  out  8  payload byte to control
- o_valid  out  1  o_data valid
- o_last  out  1  final payload byte of frame
- i_ready  in  1  control accepts o_data
- o_frame_ok  out  1  1-cycle pulse, good frame accepted
- o_frame_err  out  1  1-cycle pulse, frame dropped
- o_err_count  out  8  saturating dropped-frame counter

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_rst, synchronous and active-high.
- Reset values: all outputs 0, state HUNT, pointers 0, timeout counter 0.
- Pop handshake:
  - o_req is asserted for one cycle when i_rx_ready=1, state is not DRAIN, and o_req was 0 in the previous cycle. Pops therefore occur at most every other cycle.
  - i_data is captured in the same cycle o_req=1.
- FSM:
  - HUNT: pop bytes. A byte equal to SYNC_BYTE goes to LEN; any other byte is discarded silently, with no error.
  - LEN: pop the byte into len. If len==0 or len>MAX_LEN: error, go to HUNT. Otherwise clear the write pointer and the checksum, go to PAYLOAD.
  - PAYLOAD: each pop writes buf[wptr], wptr++, and updates the checksum. After len bytes, go to CHK.
  - CHK: pop the byte. If it equals the checksum: pulse o_frame_ok, clear the read pointer, go to DRAIN. Otherwise: error, go to HUNT.
  - DRAIN: o_req is held 0. Present buf[rptr].
    - o_valid=1 from the cycle after CHK capture.
    - o_last=1 when rptr==len-1.
    - Advance on o_valid&i_ready.
    - After the last handshake, o_valid drops in the next cycle and the state goes to HUNT.
    - o_data and o_last are held stable while o_valid=1 and i_ready=0.
- Checksum: XOR of all payload bytes, 8 bits. LEN and SYNC are excluded.
- Timeout:
  - The counter clears on every pop and increments each cycle while in LEN, PAYLOAD or CHK.
  - When it reaches TIMEOUT_CYCLES-1: error, go to HUNT.
  - Inactive in HUNT and DRAIN.
- Error action:
  - o_frame_err pulses 1 cycle, in the cycle after detection.
  - o_err_count increments, saturating at 255.
  - Partial buffer contents are discarded; nothing is ever emitted for a bad frame.
- A SYNC_BYTE value inside LEN, PAYLOAD or CHK is treated as data. There is no resync mid-frame.
- i_rst mid-frame or mid-DRAIN returns to HUNT immediately. Any in-flight frame is lost, and o_valid is 0 in the cycle following reset.
- A timeout and a pop in the same cycle: the pop wins, so the counter clears.

Optional Feature:
- Macro: UART_FRAME_CRC8_EN.
- Defined: CHK is CRC-8 over the payload bytes, MSB first, poly 0x07, init 0x00, no reflection, no final XOR. The update is one byte per pop, combinational over 8 bit-steps.
- Undefined: the XOR checksum described in Behaviour. Ports and timing are identical in both builds.

Test Plan:
- Good frame: A5 03 11 22 33 00, with i_ready=1 → o_data 11,22,33 on consecutive cycles. o_last=1 on 33. o_frame_ok pulses once. o_err_count=0.
- Garbage then frame, with backpressure: 00 FF A5 02 AA 55 FF and i_ready toggling 1/0 → output AA then 55, each held stable while i_ready=0. No o_frame_err.
- Bad check: A5 02 01 02 00 → no o_valid, o_frame_err pulses once, o_err_count=1. A following good frame is still received.
- Length limits: A5 00, then A5 41 with MAX_LEN=64 → two o_frame_err pulses, o_err_count=2, state back in HUNT. A5 40 with 64 bytes and a correct CHK is accepted, with 64 outputs.
- Timeout: A5 02 11, then idle for TIMEOUT_CYCLES (sim value 100) → o_frame_err, no output. Also, i_rst asserted mid-DRAIN → o_valid=0 the next cycle.
- CRC build (UART_FRAME_CRC8_EN defined): A5 09 "123456789" F4 → accepted and 9 bytes output. The same frame with F5 → o_frame_err.

Source files
------------

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
//
// Byte-stream framer between the UART receive FIFO and the control block.
// Pops raw bytes from the FIFO and hunts for frames of the form
//     SYNC_BYTE, LEN, LEN payload bytes, CHK
// The payload is buffered internally and released on a valid/ready stream
// only after the check byte has matched. Bad, oversized or stalled frames
// are dropped and counted; nothing from a dropped frame ever reaches o_data.
//
// Optional feature (compile-time macro UART_FRAME_CRC8_EN):
//   undefined : CHK is the 8-bit XOR of all payload bytes.
//   defined   : CHK is CRC-8 over the payload (poly 0x07, init 0x00, MSB
//               first, no reflection, no final XOR), one byte per pop.
//   Ports and timing are identical in both builds.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_data       head byte of the UART RX FIFO
//   i_rx_ready   UART RX FIFO holds a byte
//   o_req        pop strobe to the UART RX FIFO (byte captured same cycle)
//   o_data       payload byte to control
//   o_valid      o_data valid
//   o_last       final payload byte of the frame
//   i_ready      control accepts o_data
//   o_frame_ok   1-cycle pulse, good frame accepted
//   o_frame_err  1-cycle pulse, frame dropped
//   o_err_count  saturating dropped-frame counter
//
// Handshakes:
//   FIFO side : a byte is consumed on every cycle with o_req=1; i_data is
//               sampled on that same edge. o_req is never high two cycles
//               in a row, so the FIFO has a full cycle to present its next
//               head byte.
//   Out side  : a payload byte transfers on every edge with
//               o_valid=1 && i_ready=1. While o_valid=1 and i_ready=0,
//               o_data and o_last hold their value; o_valid never drops
//               before the transfer completes (except on i_rst).
//
// The FSM state is kept in the signal `state` (S_* encodings below).
// -----------------------------------------------------------------------------
module uart_frame_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_rx_ready,
    output logic       o_req,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    input  logic       i_ready,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic [7:0] o_err_count
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    // FSM encodings
    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHK     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]    state;
    logic          req_q;         // o_req of the previous cycle
    logic [7:0]    len;           // payload length of the current frame
    logic [7:0]    wptr;          // buffer write pointer (PAYLOAD)
    logic [7:0]    rptr;          // buffer read pointer (DRAIN)
    logic [7:0]    chk;           // running checksum / CRC
    logic [TW-1:0] tmo_cnt;       // idle cycles since the last pop in a frame
    logic          frame_ok_q;
    logic          frame_err_q;
    logic [7:0]    err_count_q;

    logic [7:0]    buf_mem [MAX_LEN];

    // -------------------------------------------------------------------------
    // Checksum step: one payload byte folded into the accumulator.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] chk_step(input logic [7:0] acc,
                                            input logic [7:0] d);
`ifdef UART_FRAME_CRC8_EN
        logic [7:0] r;
        // Byte-wise MSB-first CRC: XOR the byte in, then 8 shift steps.
        r = acc ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
`else
        return acc ^ d;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic       pop;
    logic       in_frame;
    logic       len_bad;
    logic       chk_bad;
    logic       tmo_hit;
    logic       err_det;
    logic [7:0] chk_next;
    logic [7:0] len_m1;

    // Pops are blocked while draining and in the cycle right after a pop.
    // Gating with i_rst keeps o_req at 0 while reset is held.
    assign o_req    = !i_rst && i_rx_ready && !req_q && (state != S_DRAIN);
    assign pop      = o_req;

    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) ||
                      (state == S_CHK);

    assign len_bad  = (i_data == 8'h00) || (i_data > MAX_LEN_B);
    assign chk_bad  = (i_data != chk);
    assign chk_next = chk_step(chk, i_data);
    assign len_m1   = len - 8'd1;

    // A pop in the same cycle as the timeout wins: the frame goes on.
    assign tmo_hit  = in_frame && !pop && (tmo_cnt == TMO_LAST);

    assign err_det  = tmo_hit ||
                      (pop && (state == S_LEN) && len_bad) ||
                      (pop && (state == S_CHK) && chk_bad);

    // -------------------------------------------------------------------------
    // Main FSM, pointers, checksum, timeout and error bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_HUNT;
            req_q       <= 1'b0;
            len         <= 8'h00;
            wptr        <= 8'h00;
            rptr        <= 8'h00;
            chk         <= 8'h00;
            tmo_cnt     <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            req_q       <= o_req;
            frame_ok_q  <= 1'b0;
            // Error pulse appears in the cycle after detection.
            frame_err_q <= err_det;

            if (err_det && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end

            // Timeout counter only runs between bytes inside a frame.
            if (!in_frame || pop) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (err_det) begin
                // Partial payload is abandoned; pointers are re-armed on the
                // next good LEN byte, so the stale buffer is never read.
                state <= S_HUNT;
            end else begin
                case (state)
                    S_HUNT: begin
                        // Non-SYNC bytes are dropped silently.
                        if (pop && (i_data == SYNC_BYTE)) begin
                            state <= S_LEN;
                        end
                    end

                    S_LEN: begin
                        // Out-of-range lengths are caught by err_det.
                        if (pop) begin
                            len   <= i_data;
                            wptr  <= 8'h00;
                            chk   <= 8'h00;
                            state <= S_PAYLOAD;
                        end
                    end

                    S_PAYLOAD: begin
                        if (pop) begin
                            chk  <= chk_next;
                            wptr <= wptr + 8'd1;
                            if (wptr == len_m1) begin
                                state <= S_CHK;
                            end
                        end
                    end

                    S_CHK: begin
                        // A mismatching check byte is caught by err_det.
                        if (pop) begin
                            frame_ok_q <= 1'b1;
                            rptr       <= 8'h00;
                            state      <= S_DRAIN;
                        end
                    end

                    S_DRAIN: begin
                        if (i_ready) begin
                            if (rptr == len_m1) begin
                                state <= S_HUNT;
                            end else begin
                                rptr <= rptr + 8'd1;
                            end
                        end
                    end

                    default: begin
                        state <= S_HUNT;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Payload buffer. No reset: contents are only read after a full frame
    // has been written and checked.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (pop && (state == S_PAYLOAD)) begin
            buf_mem[wptr[AW-1:0]] <= i_data;
        end
    end

    // -------------------------------------------------------------------------
    // Output stream. Data and last are forced to 0 outside DRAIN so the
    // idle bus is clean; inside DRAIN they depend only on rptr, which moves
    // solely on a completed transfer, so they hold under backpressure.
    // -------------------------------------------------------------------------
    assign o_valid     = (state == S_DRAIN);
    assign o_data      = o_valid ? buf_mem[rptr[AW-1:0]] : 8'h00;
    assign o_last      = o_valid && (rptr == len_m1);
    assign o_frame_ok  = frame_ok_q;
    assign o_frame_err = frame_err_q;
    assign o_err_count = err_count_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_rx
//
// Directed bench for uart_frame_rx. A byte queue models the UART RX FIFO,
// stimulus tasks push frames into it and push the expected output bytes
// ({last, data}) into exp_q. A monitor pops exp_q on every output transfer
// and also tracks pulses, backpressure stability and pop spacing.
// TIMEOUT_CYCLES is shortened to 100 for simulation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_frame_rx;

    localparam int TMO = 100;

    // -------------------------------------------------------------------------
    // Clock / reset and DUT
    // -------------------------------------------------------------------------
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_rx_ready = 1'b0;
    logic       o_req;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       i_ready = 1'b1;
    logic       o_frame_ok;
    logic       o_frame_err;
    logic [7:0] o_err_count;

    always #5 i_clk = ~i_clk;

    uart_frame_rx #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (64),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_rx_ready  (i_rx_ready),
        .o_req       (o_req),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .i_ready     (i_ready),
        .o_frame_ok  (o_frame_ok),
        .o_frame_err (o_frame_err),
        .o_err_count (o_err_count)
    );

    // -------------------------------------------------------------------------
    // Bench state
    // -------------------------------------------------------------------------
    logic [7:0] rx_q[$];          // modelled UART RX FIFO
    logic [8:0] exp_q[$];         // expected {last, data}
    logic [7:0] pl [256];         // payload scratch for send_frame
    int         errors = 0;
    int         checks = 0;
    int         ok_seen = 0;
    int         err_seen = 0;
    int         valid_cyc = 0;
    int         cyc = 0;
    int         last_req_cyc = 0;
    int         err_cyc = 0;
    int         exp_err_count = 0;
    bit         ready_toggle = 1'b0;
    logic       ready_level = 1'b1;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference check byte, bit-serial for the CRC build.
    function automatic logic [7:0] frame_chk(input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
`ifdef UART_FRAME_CRC8_EN
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ pl[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
`else
            fb = 1'b0;
            c  = c ^ pl[i];
`endif
        end
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    // SYNC, LEN, pl[0..n-1], chk. Expected output only for good frames.
    task automatic send_frame(input int n, input logic [7:0] chk,
                              input bit good);
        push_byte(8'hA5);
        push_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            push_byte(pl[i]);
            if (good) exp_q.push_back({(i == n - 1), pl[i]});
        end
        push_byte(chk);
    endtask

    task automatic wait_idle(input int extra);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL wait_idle: rx_q=%0d exp_q=%0d left after %0d cycles",
                     rx_q.size(), exp_q.size(), n);
            rx_q.delete();
            exp_q.delete();
        end
        repeat (extra) @(negedge i_clk);
    endtask

    // -------------------------------------------------------------------------
    // FIFO model: a byte is popped on each edge where o_req was high.
    // -------------------------------------------------------------------------
    initial begin
        logic pend;
        forever begin
            @(negedge i_clk);
            pend = o_req;
            @(posedge i_clk);
            #1;
            if (pend && rx_q.size() > 0) void'(rx_q.pop_front());
            i_rx_ready = (rx_q.size() > 0);
            i_data     = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        end
    end

    // Consumer ready driver
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (ready_toggle) i_ready = ~i_ready;
            else              i_ready = ready_level;
        end
    end

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin
        logic       prev_req;
        logic       hold_v;
        logic [8:0] hold_d;
        logic [8:0] got;
        logic [8:0] exp;
        prev_req = 1'b0;
        hold_v   = 1'b0;
        hold_d   = '0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_rst) begin
                hold_v   = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (o_req) begin
                    last_req_cyc = cyc;
                    checks++;
                    if (prev_req || o_valid) begin
                        errors++;
                        $display("FAIL pop_spacing: o_req=1 prev_req=%0b o_valid=%0b",
                                 prev_req, o_valid);
                    end
                end
                prev_req = o_req;
                if (o_frame_ok) ok_seen++;
                if (o_frame_err) begin
                    err_seen++;
                    err_cyc = cyc;
                end
                got = {o_last, o_data};
                if (hold_v) begin
                    checks++;
                    if (!o_valid || got !== hold_d) begin
                        errors++;
                        $display("FAIL hold_stable: valid=%0b got %0h expected %0h",
                                 o_valid, got, hold_d);
                    end
                end
                if (o_valid) begin
                    valid_cyc++;
                    if (i_ready) begin
                        hold_v = 1'b0;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL out_byte: unexpected output %0h", got);
                        end else begin
                            exp = exp_q.pop_front();
                            if (got !== exp) begin
                                errors++;
                                $display("FAIL out_byte: got %0h expected %0h", got, exp);
                            end
                        end
                    end else begin
                        hold_v = 1'b1;
                        hold_d = got;
                    end
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    // Hang guard
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed tests
    // -------------------------------------------------------------------------
    initial begin
        int ok0;
        int er0;
        int v0;
        int n;

        // ---- reset state ----
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_req", o_req, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_last", o_last, 0);
        check("rst_ok", o_frame_ok, 0);
        check("rst_err", o_frame_err, 0);
        check("rst_err_count", o_err_count, 0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // ---- good frame A5 03 11 22 33 00, ready held high ----
        ok0 = ok_seen; er0 = err_seen; v0 = valid_cyc;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(3, frame_chk(3), 1);
        wait_idle(8);
        check("good_ok_pulses", ok_seen - ok0, 1);
        check("good_err_pulses", err_seen - er0, 0);
        check("good_valid_cycles", valid_cyc - v0, 3);
        check("good_err_count", o_err_count, 0);

        // ---- garbage then frame with toggling ready ----
        ok0 = ok_seen; er0 = err_seen;
        ready_toggle = 1'b1;
        push_byte(8'h00);
        push_byte(8'hFF);
        pl[0] = 8'hAA; pl[1] = 8'h55;
        send_frame(2, frame_chk(2), 1);
        wait_idle(8);
        ready_toggle = 1'b0;
        ready_level  = 1'b1;
        check("bp_ok_pulses", ok_seen - ok0, 1);
        check("bp_err_pulses", err_seen - er0, 0);

        // ---- bad check A5 02 01 02 00, then a good frame with A5 payload ----
        ok0 = ok_seen; er0 = err_seen; v0 = valid_cyc;
        pl[0] = 8'h01; pl[1] = 8'h02;
        send_frame(2, 8'h00, 0);
        exp_err_count++;
        wait_idle(8);
        check("badchk_err_pulses", err_seen - er0, 1);
        check("badchk_no_output", valid_cyc - v0, 0);
        check("badchk_err_count", o_err_count, exp_err_count);
        ok0 = ok_seen;
        pl[0] = 8'hA5; pl[1] = 8'h5A;
        send_frame(2, frame_chk(2), 1);
        wait_idle(8);
        check("after_bad_ok_pulses", ok_seen - ok0, 1);

        // ---- length limits: A5 00, A5 41 rejected; A5 40 accepted ----
        er0 = err_seen; v0 = valid_cyc;
        push_byte(8'hA5); push_byte(8'h00);
        push_byte(8'hA5); push_byte(8'h41);
        exp_err_count += 2;
        wait_idle(8);
        check("len_err_pulses", err_seen - er0, 2);
        check("len_no_output", valid_cyc - v0, 0);
        check("len_err_count", o_err_count, exp_err_count);
        ok0 = ok_seen; v0 = valid_cyc;
        for (int i = 0; i < 64; i++) pl[i] = 8'(i);
        send_frame(64, frame_chk(64), 1);
        wait_idle(8);
        check("max_len_ok_pulses", ok_seen - ok0, 1);
        check("max_len_outputs", valid_cyc - v0, 64);

        // ---- timeout: A5 02 11 then idle ----
        er0 = err_seen; v0 = valid_cyc;
        push_byte(8'hA5); push_byte(8'h02); push_byte(8'h11);
        exp_err_count++;
        n = 0;
        while (rx_q.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        repeat (TMO + 20) @(negedge i_clk);
        check("tmo_err_pulses", err_seen - er0, 1);
        check("tmo_no_output", valid_cyc - v0, 0);
        // The counter clears on the pop edge, holds TMO-1 in the cycle that
        // follows TMO-1 further edges (detection), and the pulse shows one
        // cycle later: TMO+1 negedges after the negedge that saw that o_req.
        check("tmo_latency", err_cyc - last_req_cyc, TMO + 1);
        check("tmo_err_count", o_err_count, exp_err_count);

        // ---- gaps shorter than the timeout keep the frame alive ----
        ok0 = ok_seen; er0 = err_seen;
        pl[0] = 8'h77;
        exp_q.push_back({1'b1, 8'h77});
        push_byte(8'hA5);
        repeat (80) @(negedge i_clk);
        push_byte(8'h01);
        repeat (80) @(negedge i_clk);
        push_byte(8'h77);
        repeat (80) @(negedge i_clk);
        push_byte(frame_chk(1));
        wait_idle(8);
        check("gap_ok_pulses", ok_seen - ok0, 1);
        check("gap_err_pulses", err_seen - er0, 0);

`ifdef UART_FRAME_CRC8_EN
        // ---- CRC-8 check value of "123456789" is F4 ----
        ok0 = ok_seen; er0 = err_seen; v0 = valid_cyc;
        for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
        send_frame(9, 8'hF4, 1);
        wait_idle(8);
        check("crc_ok_pulses", ok_seen - ok0, 1);
        check("crc_outputs", valid_cyc - v0, 9);
        er0 = err_seen; v0 = valid_cyc;
        send_frame(9, 8'hF5, 0);
        exp_err_count++;
        wait_idle(8);
        check("crc_bad_err_pulses", err_seen - er0, 1);
        check("crc_bad_no_output", valid_cyc - v0, 0);
`endif

        // ---- reset in the middle of DRAIN ----
        ok0 = ok_seen;
        ready_level = 1'b0;
        pl[0] = 8'hC3; pl[1] = 8'h3C;
        send_frame(2, frame_chk(2), 0);
        n = 0;
        while (!o_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_reached", o_valid, 1);
        check("drain_ok_pulses", ok_seen - ok0, 1);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_drain_valid", o_valid, 0);
        check("rst_drain_err_count", o_err_count, 0);
        ready_level = 1'b1;
        repeat (2) @(negedge i_clk);

        // ---- recovery after reset ----
        ok0 = ok_seen;
        pl[0] = 8'h0F; pl[1] = 8'hF0; pl[2] = 8'hA5;
        send_frame(3, frame_chk(3), 1);
        wait_idle(8);
        check("recover_ok_pulses", ok_seen - ok0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
